// File: rtl/nibser_pkg.sv
// Shared types and constants for the nibble serializer; frame length follows NIBSER_PARITY_EN.
// No logic here: purely combinational constants, no latency, no backpressure.
package nibser_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } nibser_state_e;

`ifdef NIBSER_PARITY_EN
  localparam int FRAME_LEN = NIB_W + 1;
`else
  localparam int FRAME_LEN = NIB_W;
`endif

endpackage

// File: rtl/nibser_fifo.sv
// Nibble FIFO, DEPTH entries; head is visible the cycle after the push that filled it.
// Backpressure: push ignored while full, pop ignored while empty.
module nibser_fifo
  import nibser_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [NIB_W-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [NIB_W-1:0] head
);

  logic [NIB_W-1:0] mem_q [DEPTH];
  logic [NIB_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Buffers nibbles and shifts each out LSB-first (plus even parity when NIBSER_PARITY_EN); first bit 2 cycles after accept.
// Backpressure: i_sd_ready low freezes the lane; o_ready drops while the FIFO is full.
module nibble_serializer
  import nibser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [NIB_W-1:0]             i_data,
  output logic                         o_ready,
  output logic                         o_sd,
  output logic                         o_sd_valid,
  output logic                         o_sd_last,
  input  logic                         i_sd_ready,
  output logic                         o_busy,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  nibser_state_e    state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [NIB_W-1:0] shreg_q, shreg_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic [NIB_W-1:0] fifo_head;
  logic             fifo_pop;
  logic             push_vld;
  logic             frame_done;

  assign o_ready  = !fifo_full;
  assign push_vld = i_valid && o_ready;
  assign o_busy   = (state_q != IDLE);

  nibser_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push     (push_vld),
    .push_dat (i_data),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (o_count),
    .head     (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    o_sd       = 1'b0;
    o_sd_valid = 1'b0;
    o_sd_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_head;
          idx_d    = 2'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        o_sd       = shreg_q[idx_q];
        o_sd_valid = 1'b1;
`ifndef NIBSER_PARITY_EN
        o_sd_last  = (idx_q == 2'd3);
`endif
        if (i_sd_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef NIBSER_PARITY_EN
            state_d = PAR;
`else
            frame_done = 1'b1;
`endif
          end
        end
      end
`ifdef NIBSER_PARITY_EN
      PAR: begin
        o_sd       = ^shreg_q;
        o_sd_valid = 1'b1;
        o_sd_last  = 1'b1;
        frame_done = i_sd_ready;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Reload on the closing edge so consecutive frames have no idle gap.
    if (frame_done) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shreg_d  = fifo_head;
        idx_d    = 2'd0;
        state_d  = DATA;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Downstream consumer of the 4-bit registered nibble stream produced by the per-bit flop stage (`o_a`). It buffers incoming nibbles in a small FIFO and shifts each one out LSB-first on a single-bit serial lane with a valid/ready handshake toward the next stage. It decouples the parallel capture path from a serial sink that may stall.

## Interface
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `i_clk`  in  1  sole clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  upstream nibble present on `i_data`.
- `i_data`  in  4  upstream nibble, driven from the flop stage's `o_a`.
- `o_ready`  out  1  FIFO can accept; a transfer occurs on an edge where `i_valid && o_ready`.
- `o_sd`  out  1  serial data bit.
- `o_sd_valid`  out  1  `o_sd` holds a valid bit.
- `o_sd_last`  out  1  the current bit is the last bit of its frame.
- `i_sd_ready`  in  1  sink accepts the current bit on an edge where `o_sd_valid && i_sd_ready`.
- `o_busy`  out  1  FSM is not in IDLE.
- `o_count`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- FIFO push on `i_valid && o_ready`. `o_ready = !full`. No push while full, even if a pop happens on the same edge.
- FSM states: IDLE, DATA, and PAR (PAR exists only with the parity macro).
- IDLE: if the FIFO is non-empty, pop the head into the 4-bit shift register, set bit index to 0, and go to DATA. Otherwise stay in IDLE.
- DATA: `o_sd = shreg[idx]`, `o_sd_valid = 1`. On each accepted bit, `idx` increments (2-bit counter).
  - Accepted bit with `idx == 3` and no parity: go to IDLE, or reload (see Timing).
  - Accepted bit with `idx == 3` and parity enabled: go to PAR.
- `o_sd_last` is high when `idx == 3` in DATA without parity, or in PAR.
- While `i_sd_ready` is low, `o_sd`, `o_sd_valid`, `o_sd_last`, `idx` and state all hold unchanged.
- `o_count` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Reset: FIFO empty and pointers at 0, state IDLE, `idx = 0`, shift register 0. Reset overrides any in-flight frame, which is discarded without a partial completion.
- Reset values: `o_ready = 1`, `o_sd = 0`, `o_sd_valid = 0`, `o_sd_last = 0`, `o_busy = 0`, `o_count = 0`.

## Timing
- An upstream push on edge N makes the FIFO non-empty in cycle N+1. The IDLE load happens at edge N+1, and the first bit is valid in cycle N+2. Latency from accept to first bit is 2 cycles.
- Back-to-back frames: when the last bit is accepted and the FIFO is non-empty, the next nibble loads on the same edge. The next frame's bit 0 is valid the following cycle, with no idle gap.
- Without parity, sustained throughput is 4 cycles per nibble when `i_sd_ready` is held high.
- Push into a FIFO that is popped to empty on the same edge is legal. The pushed entry is then seen as non-empty next cycle.
- Pointers wrap modulo DEPTH. Full and empty are derived from `o_count`.

## Configuration
- `NIBSER_PARITY_EN` defined:
  - Each frame is 5 bits: 4 data bits, then one PAR bit equal to the XOR of the 4 data bits (even parity).
  - The parity bit carries `o_sd_last`.
  - Throughput is 5 cycles per nibble.
- `NIBSER_PARITY_EN` undefined:
  - PAR state and parity logic are absent.
  - Frames are 4 bits and `o_sd_last` is on bit 3.

## Structure
- Shared package `nibser_pkg`:
  - state enum `nibser_state_e` (IDLE, DATA, PAR).
  - `NIB_W = 4`.
  - frame-length constant, selected by the macro.
- One sub-module, `nibser_fifo`:
  - parameterised `DEPTH`, 4-bit data.
  - ports: push, pop, full, empty, count, head.
  - synchronous reset.
- `nibble_serializer` instantiates `nibser_fifo` and holds the FSM, shift register and index counter.

## Test plan
- Reset check: after reset, `o_ready = 1`, `o_sd_valid = 0`, `o_count = 0`, `o_busy = 0`.
- Single nibble with sink always ready: push 4'b1011 → `o_sd` = 1, 1, 0, 1 in 4 consecutive cycles starting 2 cycles after the push, with `o_sd_last` on the 4th bit. With parity, a 5th bit of 1 follows and carries `o_sd_last`.
- Sink stall: push 4'b0110, drop `i_sd_ready` during bit 1 for 3 cycles → `o_sd` holds 1 and `o_sd_valid` stays high for all 3 cycles. The sequence then resumes 0, 1, 1, 0 with no bit lost or duplicated.
- Full FIFO: hold `i_sd_ready = 0` and push 5 nibbles 1, 2, 3, 4, 5 → with DEPTH 4, one nibble sits in the shift register and 4 in the FIFO. `o_ready` drops to 0 and `o_count = 4`. Releasing the sink delivers all 5 nibbles in order, and `o_ready` returns to 1 after the first pop.
- Back-to-back: preload 4'hA and 4'h5 → 8 consecutive valid bits 0, 1, 0, 1, 1, 0, 1, 0 with no gap, and `o_sd_last` on bits 4 and 8.
- Reset mid-frame: assert `i_rst` during bit 2 of a frame with 2 entries queued → the next cycle shows `o_sd_valid = 0` and `o_count = 0`, and no remaining bits are emitted.
